// File: rtl/rand_pkg.sv
// Shared constants, FSM state encoding and the clog2 helper for the bounded random sampler.
package rand_pkg;

  localparam int RAND_W        = 13;
  localparam int DEF_RANGE     = 10;
  localparam int DEF_MAX_TRIES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rand_range_check.sv
// Combinational range test of a K-bit candidate against RANGE, plus the folded fallback symbol.
// Zero latency; no flow control.
module rand_range_check
  import rand_pkg::*;
#(
  parameter int RANGE = DEF_RANGE,
  parameter int K     = clog2(DEF_RANGE)
) (
  input  logic [K-1:0] candidate,
  output logic         in_range,
  output logic [K-1:0] fallback
);

  // One extra bit so RANGE == 2^K still compares correctly.
  localparam logic [K:0] RANGE_W = (K + 1)'(RANGE);

  assign in_range = ({1'b0, candidate} < RANGE_W);

  // candidate >= RANGE and candidate < 2*RANGE, so the K-bit modular difference is exact.
  assign fallback = candidate - RANGE_W[K-1:0];

endmodule

// File: rtl/rand_range_sampler.sv
// Rejection sampler: maps rand_in onto 0..RANGE-1, folding into range after MAX_TRIES rejections.
// Latency 1+r cycles from req; the symbol is held until out_ready, and requests arriving while busy are counted and dropped.
module rand_range_sampler
  import rand_pkg::*;
#(
  parameter int RANGE     = DEF_RANGE,
  parameter int MAX_TRIES = DEF_MAX_TRIES,
  localparam int K        = clog2(RANGE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RAND_W-1:0] rand_in,
  input  logic              req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [K-1:0]      out_value,
  output logic              out_fallback,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  state_t       state, state_nxt;
  logic [3:0]   tries, tries_nxt;
  logic         valid_nxt, fallback_nxt;
  logic [K-1:0] value_nxt;
  logic [7:0]   drop_nxt;
  logic         in_range;
  logic [K-1:0] fold_value;
  logic         unused_rand;

  assign unused_rand = ^rand_in[RAND_W-1:K];

  rand_range_check #(
    .RANGE (RANGE),
    .K     (K)
  ) u_check (
    .candidate (rand_in[K-1:0]),
    .in_range  (in_range),
    .fallback  (fold_value)
  );

  always_comb begin
    state_nxt    = state;
    tries_nxt    = tries;
    valid_nxt    = out_valid;
    value_nxt    = out_value;
    fallback_nxt = out_fallback;
    drop_nxt     = drop_cnt;

    if (req && (state != ST_IDLE) && (drop_cnt != 8'hFF)) drop_nxt = drop_cnt + 8'd1;

    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nxt = ST_SAMPLE;
          tries_nxt = 4'd0;
        end
      end
      ST_SAMPLE: begin
        if (in_range) begin
          value_nxt    = rand_in[K-1:0];
          fallback_nxt = 1'b0;
          valid_nxt    = 1'b1;
          state_nxt    = ST_HOLD;
        end else if (tries == LAST_TRY) begin
          value_nxt    = fold_value;
          fallback_nxt = 1'b1;
          valid_nxt    = 1'b1;
          state_nxt    = ST_HOLD;
        end else begin
          tries_nxt = tries + 4'd1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      tries        <= 4'd0;
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_fallback <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      state        <= state_nxt;
      tries        <= tries_nxt;
      out_valid    <= valid_nxt;
      out_value    <= value_nxt;
      out_fallback <= fallback_nxt;
      drop_cnt     <= drop_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/rand_range_sampler.md
RAND_RANGE_SAMPLER -- requirements
Module: rand_range_sampler

Interface
REQ-001 Parameter RANGE, default 10: number of output symbols; legal 2..4096.
REQ-002 Parameter MAX_TRIES, default 8: sample attempts before fallback; legal 1..15.
REQ-003 Derived constant K = ceil(log2(RANGE)): sample width; also the width of out_value.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rand_in  in  13  free-running LFSR value from the upstream generator; a new value every cycle.
REQ-007 req  in  1  request for one bounded random symbol; level-sampled each cycle.
REQ-008 out_ready  in  1  consumer accepts out_value this cycle.
REQ-009 out_valid  out  1  out_value holds a symbol awaiting acceptance.
REQ-010 out_value  out  K  symbol, always in 0..RANGE-1.
REQ-011 out_fallback  out  1  the current symbol came from the fallback path; qualified by out_valid.
REQ-012 busy  out  1  high in SAMPLE and HOLD.
REQ-013 drop_cnt  out  8  saturating count of requests that were ignored.

Function
REQ-014 FSM states: IDLE, SAMPLE, HOLD.
REQ-015 Transitions:
  - IDLE with req=1 -> SAMPLE; clear the try counter.
  - IDLE with req=0 -> stay in IDLE.
REQ-016 SAMPLE, each cycle: candidate c = rand_in[K-1:0].
  - c < RANGE: load out_value=c, out_fallback=0, out_valid=1; -> HOLD.
  - c >= RANGE, try counter < MAX_TRIES-1: increment the try counter; stay in SAMPLE; next cycle uses the next rand_in.
  - c >= RANGE, try counter = MAX_TRIES-1: load out_value=c-RANGE, out_fallback=1, out_valid=1; -> HOLD.
REQ-017 HOLD: out_value and out_fallback are held stable while out_valid=1 and out_ready=0.
REQ-018 HOLD with out_ready=1: handshake completes; out_valid=0 on the next cycle; -> IDLE.
REQ-019 Latency: req seen at edge n with r rejections before acceptance -> out_valid high after edge n+1+r. Worst case r = MAX_TRIES-1.
REQ-020 A req=1 sampled in SAMPLE or HOLD (including the handshake cycle) is dropped and increments drop_cnt. drop_cnt saturates at 255.
REQ-021 out_ready while out_valid=0 has no effect.
REQ-022 Arithmetic is unsigned. Fallback c-RANGE is always < RANGE because c < 2^K < 2*RANGE.
REQ-023 When RANGE is a power of two, rejection never occurs and out_fallback stays 0.
REQ-024 The try counter is 4 bits wide and never wraps.

Reset
REQ-025 reset=1 at an edge forces, with priority over all other inputs:
  - state = IDLE, try counter = 0;
  - out_valid = 0, out_value = 0, out_fallback = 0;
  - busy = 0, drop_cnt = 0.
REQ-026 Reset asserted in SAMPLE or HOLD abandons the pending symbol; no handshake occurs for it.
REQ-027 req is ignored in the cycle reset is high; the first req can be accepted at the first edge after reset deasserts.

Structure
REQ-028 Shared package rand_pkg holds:
  - RAND_W = 13;
  - the FSM state enum;
  - RANGE and MAX_TRIES defaults;
  - a clog2 helper function.
REQ-029 One sub-module, rand_range_check (combinational), SHALL take candidate and RANGE and produce in_range and the fallback value; the FSM lives in rand_range_sampler.
REQ-030 No other storage besides the state, try counter, output registers and drop_cnt.

Verification
REQ-031 RANGE=10, req pulse at edge 0, rand_in low nibble = 7 at edge 1 -> out_valid=1 after edge 1, out_value=7, out_fallback=0.
REQ-032 RANGE=10, low nibbles 12, 15, 3 on successive SAMPLE cycles -> two rejections, out_value=3 after the third SAMPLE edge.
REQ-033 RANGE=10, MAX_TRIES=8, low nibble held at 13 for 8 cycles -> out_value=3, out_fallback=1, valid after edge 8.
REQ-034 Valid symbol with out_ready=0 for 5 cycles, req pulsed twice meanwhile -> out_value stable; drop_cnt=2; single handshake on out_ready=1; back to IDLE.
REQ-035 reset asserted in SAMPLE, then in HOLD -> next cycle all outputs zero and state IDLE; req after reset is served normally.
REQ-036 Random stimulus over 10k requests, RANGE in {3, 10, 16, 100} -> every accepted out_value < RANGE; histogram within 5% of uniform for non-fallback samples.
